// File: rtl/alu_if.sv
// Operand/function inputs and result outputs of the registered ALU.
// Master drives A, B and ALU_FUNC and receives every result bus and flag.
// Slave is the ALU itself; results appear one cycle after inputs, no handshake.
interface alu_if #(
  parameter int A_W = 16,
  parameter int B_W = 16
);
  localparam int OUT_W = A_W + B_W;

  logic [A_W-1:0]   A;
  logic [B_W-1:0]   B;
  logic [3:0]       ALU_FUNC;
  logic [OUT_W-1:0] Arith_OUT;
  logic             Carry_OUT;
  logic [OUT_W-1:0] Logic_OUT;
  logic [OUT_W-1:0] CMP_OUT;
  logic [OUT_W-1:0] Shift_OUT;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;

  modport master (
    output A, B, ALU_FUNC,
    input  Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
    input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
  );

  modport slave (
    input  A, B, ALU_FUNC,
    output Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
    output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
  );
endinterface

// File: rtl/alu_top_unit.sv
// Registered 16-function ALU (arith, logic, compare, shift) selected by ALU_FUNC[3:2].
// Latency: 1 cycle, a new function may be issued every cycle.
// Backpressure: none; results and one-hot unit flags are registered every edge.
// Ports: CLK (rising edge), rst (async active-high, clears all outputs),
//        bus (alu_if.slave): A, B, ALU_FUNC in; *_OUT buses, Carry_OUT, *_Flag out.
module alu_top_unit #(
  parameter int A_WIDTH_TOP = 16,
  parameter int B_WIDTH_TOP = 16
) (
  input  logic  CLK,
  input  logic  rst,
  alu_if.slave  bus
);
  localparam int OUT_W = A_WIDTH_TOP + B_WIDTH_TOP;

  // Both operands zero-extended to the full result width before any operation,
  // so the product, the wrap-around difference and the shifts lose no bits.
  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] diff;

  assign a_ext = {{B_WIDTH_TOP{1'b0}}, bus.A};
  assign b_ext = {{A_WIDTH_TOP{1'b0}}, bus.B};
  assign sum   = a_ext + b_ext;
  assign diff  = a_ext - b_ext;

  logic [OUT_W-1:0] arith_n;
  logic             carry_n;
  logic [OUT_W-1:0] logic_n;
  logic [OUT_W-1:0] cmp_n;
  logic [OUT_W-1:0] shift_n;
  logic             arith_flag_n;
  logic             logic_flag_n;
  logic             cmp_flag_n;
  logic             shift_flag_n;

  always_comb begin
    arith_n      = '0;
    carry_n      = 1'b0;
    logic_n      = '0;
    cmp_n        = '0;
    shift_n      = '0;
    arith_flag_n = 1'b0;
    logic_flag_n = 1'b0;
    cmp_flag_n   = 1'b0;
    shift_flag_n = 1'b0;

    unique case (bus.ALU_FUNC[3:2])
      2'b00: begin
        arith_flag_n = 1'b1;
        unique case (bus.ALU_FUNC[1:0])
          2'b00: begin
            arith_n = sum;
            carry_n = sum[A_WIDTH_TOP];
          end
          2'b01: begin
            // Bit A_WIDTH_TOP of the wrapped difference doubles as the borrow.
            arith_n = diff;
            carry_n = diff[A_WIDTH_TOP];
          end
          2'b10:   arith_n = a_ext * b_ext;
          default: arith_n = (b_ext == '0) ? '0 : (a_ext / b_ext);
        endcase
      end
      2'b01: begin
        logic_flag_n = 1'b1;
        // Computed at full width: the inverting forms set all upper bits.
        unique case (bus.ALU_FUNC[1:0])
          2'b00:   logic_n = a_ext & b_ext;
          2'b01:   logic_n = a_ext | b_ext;
          2'b10:   logic_n = ~(a_ext & b_ext);
          default: logic_n = ~(a_ext | b_ext);
        endcase
      end
      2'b10: begin
        cmp_flag_n = 1'b1;
        unique case (bus.ALU_FUNC[1:0])
          2'b00:   cmp_n = '0;
          2'b01:   cmp_n = (a_ext == b_ext) ? OUT_W'(1) : '0;
          2'b10:   cmp_n = (a_ext >  b_ext) ? OUT_W'(2) : '0;
          default: cmp_n = (a_ext <  b_ext) ? OUT_W'(3) : '0;
        endcase
      end
      default: begin
        shift_flag_n = 1'b1;
        unique case (bus.ALU_FUNC[1:0])
          2'b00:   shift_n = a_ext >> 1;
          2'b01:   shift_n = a_ext << 1;
          2'b10:   shift_n = b_ext >> 1;
          default: shift_n = b_ext << 1;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      bus.Arith_OUT  <= '0;
      bus.Carry_OUT  <= 1'b0;
      bus.Logic_OUT  <= '0;
      bus.CMP_OUT    <= '0;
      bus.Shift_OUT  <= '0;
      bus.Arith_Flag <= 1'b0;
      bus.Logic_Flag <= 1'b0;
      bus.CMP_Flag   <= 1'b0;
      bus.Shift_Flag <= 1'b0;
    end else begin
      bus.Arith_OUT  <= arith_n;
      bus.Carry_OUT  <= carry_n;
      bus.Logic_OUT  <= logic_n;
      bus.CMP_OUT    <= cmp_n;
      bus.Shift_OUT  <= shift_n;
      bus.Arith_Flag <= arith_flag_n;
      bus.Logic_Flag <= logic_flag_n;
      bus.CMP_Flag   <= cmp_flag_n;
      bus.Shift_Flag <= shift_flag_n;
    end
  end
endmodule

// File: tb/tb_alu_top_unit.sv
module tb_alu_top_unit;
  logic CLK;
  logic rst;
  int   cycle;
  int   errors;
  int   checks;

  alu_if #(.A_W(16), .B_W(16)) bus ();

  alu_top_unit #(.A_WIDTH_TOP(16), .B_WIDTH_TOP(16)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  typedef struct {
    int          due;
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] arith;
    logic        carry;
    logic [31:0] lgc;
    logic [31:0] cmp;
    logic [31:0] sh;
    logic [3:0]  flags;   // {Arith, Logic, CMP, Shift}
  } exp_t;

  exp_t sb[$];

  // Reference model: plain 64-bit arithmetic reduced mod 2^32.
  function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint unsigned x, y, r, m;
    x = 64'(a);
    y = 64'(b);
    m = 64'hFFFF_FFFF;
    r = 0;
    e.func = f; e.a = a; e.b = b; e.due = 0;
    e.arith = 0; e.carry = 0; e.lgc = 0; e.cmp = 0; e.sh = 0; e.flags = 0;
    case (f)
      4'd0:  begin r = x + y; e.arith = 32'(r & m); e.carry = r[16]; end
      4'd1:  begin r = (x - y) & m; e.arith = 32'(r); e.carry = r[16]; end
      4'd2:  e.arith = 32'((x * y) & m);
      4'd3:  e.arith = (y == 0) ? 32'd0 : 32'(x / y);
      4'd4:  e.lgc = 32'(x & y);
      4'd5:  e.lgc = 32'(x | y);
      4'd6:  e.lgc = 32'(~(x & y) & m);
      4'd7:  e.lgc = 32'(~(x | y) & m);
      4'd8:  e.cmp = 0;
      4'd9:  e.cmp = (x == y) ? 32'd1 : 32'd0;
      4'd10: e.cmp = (x > y)  ? 32'd2 : 32'd0;
      4'd11: e.cmp = (x < y)  ? 32'd3 : 32'd0;
      4'd12: e.sh = 32'(x / 2);
      4'd13: e.sh = 32'(x * 2);
      4'd14: e.sh = 32'(y / 2);
      default: e.sh = 32'(y * 2);
    endcase
    if (f < 4)       e.flags = 4'b1000;
    else if (f < 8)  e.flags = 4'b0100;
    else if (f < 12) e.flags = 4'b0010;
    else             e.flags = 4'b0001;
    return e;
  endfunction

  // Monitor: compares the registered result against the oldest pending expectation.
  always @(negedge CLK) begin
    if (sb.size() != 0 && sb[0].due <= cycle) begin
      exp_t e;
      logic [3:0] fl;
      e  = sb.pop_front();
      fl = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
      checks = checks + 1;
      if (bus.Arith_OUT !== e.arith || bus.Carry_OUT !== e.carry || bus.Logic_OUT !== e.lgc ||
          bus.CMP_OUT !== e.cmp || bus.Shift_OUT !== e.sh || fl !== e.flags) begin
        errors = errors + 1;
        $display("FAIL op func=%b A=%h B=%h got arith=%h c=%b log=%h cmp=%h sh=%h fl=%b need arith=%h c=%b log=%h cmp=%h sh=%h fl=%b",
                 e.func, e.a, e.b, bus.Arith_OUT, bus.Carry_OUT, bus.Logic_OUT, bus.CMP_OUT,
                 bus.Shift_OUT, fl, e.arith, e.carry, e.lgc, e.cmp, e.sh, e.flags);
      end
    end
  end

  // Called at posedge+1; the next edge captures these inputs.
  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    bus.ALU_FUNC = f;
    bus.A        = a;
    bus.B        = b;
    e     = model(f, a, b);
    e.due = cycle + 1;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s: %0d results never appeared, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    logic [135:0] got;
    got = {bus.Arith_OUT, bus.Carry_OUT, bus.Logic_OUT, bus.CMP_OUT, bus.Shift_OUT,
           bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
    checks = checks + 1;
    if (got !== '0) begin
      errors = errors + 1;
      $display("FAIL %s: outputs=%h required all zero", name, got);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'(($urandom_range(0, 15)));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  f;
    logic [15:0] a, b;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.ALU_FUNC = 4'd0;
    bus.A = 16'd0;
    bus.B = 16'd0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    // Directed vectors from the test plan.
    issue(4'b0000, 16'd15,   16'd5);
    issue(4'b0000, 16'hFFFF, 16'd1);
    issue(4'b0001, 16'd15,   16'd5);
    issue(4'b0001, 16'd5,    16'd6);
    issue(4'b0010, 16'd319,  16'd243);
    issue(4'b0011, 16'd15,   16'd5);
    issue(4'b0011, 16'd5,    16'd15);
    issue(4'b0011, 16'd15,   16'd0);
    issue(4'b0010, 16'hFFFF, 16'hFFFF);
    drain("arith_drain");

    // Reset with live inputs, then asynchronously between edges.
    issue(4'b0000, 16'd15, 16'd5);
    drain("pre_reset_drain");
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset_mid_cycle");
    @(posedge CLK);
    #1;
    check_zero("reset_held_over_edge");
    rst = 1'b0;

    for (int i = 4; i < 8; i++)  issue(4'(i), 16'd15, 16'd5);
    issue(4'b1001, 16'd5,  16'd5);
    issue(4'b1001, 16'd15, 16'd5);
    issue(4'b1010, 16'd15, 16'd5);
    issue(4'b1010, 16'd15, 16'd31);
    issue(4'b1011, 16'd15, 16'd5);
    issue(4'b1011, 16'd15, 16'd31);
    issue(4'b1000, 16'd15, 16'd5);
    for (int i = 12; i < 16; i++) issue(4'(i), 16'd15, 16'd15);
    issue(4'b1101, 16'hFFFF, 16'h8000);
    issue(4'b1111, 16'hFFFF, 16'h8000);
    drain("directed_drain");

    // Randomised back-to-back traffic.
    for (int i = 0; i < 400; i++) begin
      f = 4'($urandom_range(0, 15));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? a : pick();
      issue(f, a, b);
    end
    drain("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
